uart_tx_result: RTL and testbench

UART_TX_RESULT -- requirements
Module: uart_tx_result

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/hex_to_ascii.sv | 16 +
 rtl/uart_tx_result.sv | 113 +++++++++++
 tb/tb_uart_tx_result.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the result-to-UART hex printer.
//   state_t  : frame FSM states
//   ASCII_*  : character codes used to build a frame
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: combinational nibble to uppercase ASCII hex digit.
//   nibble : input  [3:0] value 0-15
//   ascii  : output [7:0] '0'-'9' or 'A'-'F'
module hex_to_ascii
  import uart_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'd0, nibble};
    else                ascii = ASCII_A + {4'd0, nibble} - 8'd10;
  end

endmodule

// File: rtl/uart_tx_result.sv
// uart_tx_result: sends an N-bit result as N/4 uppercase hex digits, MSB
// nibble first, over a byte-wide UART transmitter handshake.
// Build option: define UART_TX_CRLF_EN to append CR, LF to every frame.
//   clock    : input        system clock, rising edge
//   reset    : input        synchronous active-high reset
//   trigger  : input        accepted only in IDLE; latches result
//   result   : input  [N]   value to print
//   tx_busy  : input        transmitter busy
//   tx_start : output       one-cycle send request for tx_data
//   tx_data  : output [8]   character, held until the next tx_start
//   busy     : output       frame in progress
module uart_tx_result
  import uart_tx_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         trigger,
  input  logic [N-1:0] result,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         busy
);

  localparam int NDIG = N / 4;
`ifdef UART_TX_CRLF_EN
  localparam int NCHAR = NDIG + 2;
`else
  localparam int NCHAR = NDIG;
`endif
  localparam int CW = $clog2(NCHAR + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHAR - 1);
`ifdef UART_TX_CRLF_EN
  localparam logic [CW-1:0] CNT_CR = CW'(NDIG);
  localparam logic [CW-1:0] CNT_LF = CW'(NDIG + 1);
`endif

  state_t        state, state_nxt;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [7:0]    hex_char, cur_char;
  logic          load, fire, adv;

  hex_to_ascii u_hex (
    .nibble (sr[N-1 -: 4]),
    .ascii  (hex_char)
  );

`ifdef UART_TX_CRLF_EN
  always_comb begin
    if      (cnt == CNT_CR) cur_char = ASCII_CR;
    else if (cnt == CNT_LF) cur_char = ASCII_LF;
    else                    cur_char = hex_char;
  end
`else
  always_comb cur_char = hex_char;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fire      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: if (trigger) begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (!tx_busy) begin
        fire      = 1'b1;
        state_nxt = WAIT_ACK;
      end
      // one dead cycle so tx_busy has time to rise after tx_start
      WAIT_ACK: state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) begin
        adv       = 1'b1;
        state_nxt = (cnt == CNT_LAST) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tx_start/tx_data are registered: glitch-free, and tx_data only changes
  // when a new character is launched.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr       <= '0;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= fire;
      if (fire) tx_data <= cur_char;
      if (load) begin
        sr  <= result;
        cnt <= '0;
      end else if (adv) begin
        sr  <= sr << 4;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_result.sv
module tb_uart_tx_result;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] result = 16'h0000;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          n_start = 0;
  int          mcnt = 0;
  logic        hold_busy = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  always #5 clock = ~clock;

  // transmitter: busy from the cycle after tx_start for 10 cycles
  always @(posedge clock) begin
    if (tx_start)      mcnt <= 10;
    else if (mcnt > 0) mcnt <= mcnt - 1;
  end
  assign tx_busy = (mcnt != 0) || hold_busy;

  uart_tx_result #(.N(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .result   (result),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  // scoreboard monitor
  always @(negedge clock) begin
    if (tx_start) begin
      n_start++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start got=%02h expected=none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_data got=%02h expected=%02h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
`ifdef UART_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic send_frame(input logic [15:0] v);
    trigger = 1'b1;
    result  = v;
    tick();
    trigger = 1'b0;
    result  = 16'hDEAD;   // must not leak into the frame
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 600) begin
      tick();
      k++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_bytes_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (n_start < n && k < 600) begin
      tick();
      k++;
    end
    check("wait_tx_start", {31'd0, (n_start >= n)}, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_no_trigger", {31'd0, busy}, 32'd0);

    // basic frame
    push4(8'h31, 8'h41, 8'h33, 8'h46);
    send_frame(16'h1A3F);
    wait_idle("f1A3F");

    // boundary values
    push4(8'h30, 8'h30, 8'h30, 8'h30);
    send_frame(16'h0000);
    wait_idle("f0000");
    push4(8'h46, 8'h46, 8'h46, 8'h46);
    send_frame(16'hFFFF);
    wait_idle("fFFFF");

    // trigger while busy, held through the return-to-IDLE edge
    n0 = n_start;
    push4(8'h30, 8'h30, 8'h41, 8'h42);
    send_frame(16'h00AB);
    wait_starts(n0 + 2);
    trigger = 1'b1;
    result  = 16'h1234;
    begin
      int k = 0;
      while (busy && k < 600) begin
        tick();
        k++;
      end
    end
    trigger = 1'b0;
    check("ignored_idle", {31'd0, busy}, 32'd0);
    repeat (60) tick();
    check("ignored_still_idle", {31'd0, busy}, 32'd0);
`ifdef UART_TX_CRLF_EN
    check("ignored_count", n_start - n0, 32'd6);
`else
    check("ignored_count", n_start - n0, 32'd4);
`endif
    check("ignored_bytes_left", exp_q.size(), 32'd0);

    // back-pressure
    hold_busy = 1'b1;
    push4(8'h42, 8'h45, 8'h45, 8'h46);
    send_frame(16'hBEEF);
    n0 = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_start) n0++;
    end
    check("bp_no_start", n0, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    hold_busy = 1'b0;
    wait_idle("fBEEF");

    // reset mid-frame
    n0 = n_start;
    push4(8'h39, 8'h38, 8'h37, 8'h36);
    send_frame(16'h9876);
    wait_starts(n0 + 3);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("midrst_no_resume", {31'd0, busy}, 32'd0);
    push4(8'h30, 8'h30, 8'h43, 8'h35);
    send_frame(16'h00C5);
    wait_idle("f00C5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
